// File: rtl/int_arbiter.sv
// int_arbiter: level-sensitive interrupt gateways plus priority arbiter with an MMIO claim/complete port.
// Latency: irq_i to int_flag_o 2 cycles; register read to data_o 1 cycle; config change to int_flag_o 1 cycle after the write edge.
// Backpressure: none; every strobe is accepted, and a write wins over a simultaneous read, which is dropped.
module int_arbiter #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [7:0]       addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    output logic [7:0]       int_flag_o
);

    // Per-source gateway: waiting for a request, holding a request, or being serviced.
    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_INSV = 2'd2
    } gw_state_t;

    // Decoded view of one register-port cycle.
    typedef struct packed {
        logic       wr;        // write performed this cycle
        logic       rd;        // read performed this cycle (dropped on collision)
        logic       claim;     // read of CLAIM/COMPLETE
        logic       cmpl;      // write of CLAIM/COMPLETE
        logic       prio_hit;  // word address lands on a PRIORITY register
        logic [5:0] word;      // word address
        logic [5:0] prio_idx;  // source index of the PRIORITY register addressed
    } reg_req_t;

    localparam logic [5:0] W_PENDING   = 6'd0;
    localparam logic [5:0] W_ENABLE    = 6'd1;
    localparam logic [5:0] W_THRESH    = 6'd2;
    localparam logic [5:0] W_CLAIM     = 6'd3;
    localparam logic [5:0] W_PRIO_BASE = 6'd4;
    localparam logic [5:0] N_SRC_W     = 6'(N_SRC);

    gw_state_t         gw_q     [N_SRC];
    gw_state_t         gw_d     [N_SRC];
    logic [N_SRC-1:0]  enable_q;
    logic [PRIO_W-1:0] thresh_q;
    logic [PRIO_W-1:0] prio_q   [N_SRC];

    reg_req_t          req;
    logic [7:0]        cmpl_id;
    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  eligible;
    logic [7:0]        winner;
    logic [PRIO_W-1:0] win_prio;
    logic [31:0]       rd_data;

    // Only the low byte carries a completion ID and byte-lane bits are ignored;
    // fold the rest into a sink so unused upper bits stay visibly intentional.
    logic unused_bits;
    assign unused_bits = ^{data_i[31:8], addr_i[1:0]};

    assign cmpl_id = data_i[7:0];

    // Decode the register strobe; a simultaneous write suppresses the read entirely.
    always_comb begin
        req          = '0;
        req.word     = addr_i[7:2];
        req.wr       = we_i;
        req.rd       = re_i & ~we_i;
        req.claim    = req.rd && (req.word == W_CLAIM);
        req.cmpl     = req.wr && (req.word == W_CLAIM);
        req.prio_idx = req.word - W_PRIO_BASE;
        req.prio_hit = (req.word >= W_PRIO_BASE) && (req.prio_idx < N_SRC_W);
    end

    // A source competes only while pending, enabled and strictly above threshold.
    always_comb begin
        pending  = '0;
        eligible = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pending[i]  = (gw_q[i] == GW_PEND);
            eligible[i] = pending[i] && enable_q[i] && (prio_q[i] > thresh_q);
        end
    end

    // Highest priority wins; strict compare keeps the lowest index on ties.
    always_comb begin
        winner   = 8'd0;
        win_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i] && ((winner == 8'd0) || (prio_q[i] > win_prio))) begin
                winner   = 8'(i + 1);
                win_prio = prio_q[i];
            end
        end
    end

    // Gateway next state: latch a level request, hand it over on claim, release on matching complete.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            gw_d[i] = gw_q[i];
            case (gw_q[i])
                GW_IDLE: begin
                    if (irq_i[i]) begin
                        gw_d[i] = GW_PEND;
                    end
                end
                GW_PEND: begin
                    // Dropping irq_i here does not cancel; the request is held until claimed.
                    if (req.claim && (winner == 8'(i + 1))) begin
                        gw_d[i] = GW_INSV;
                    end
                end
                GW_INSV: begin
                    // irq_i is ignored while in service; a still-high line re-pends after release.
                    if (req.cmpl && (cmpl_id == 8'(i + 1))) begin
                        gw_d[i] = GW_IDLE;
                    end
                end
                default: begin
                    gw_d[i] = GW_IDLE;
                end
            endcase
        end
    end

    // Gateway state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                gw_q[i] <= GW_IDLE;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                gw_q[i] <= gw_d[i];
            end
        end
    end

    // Configuration registers; they only steer eligibility and never touch gateway state.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
            thresh_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                prio_q[i] <= '0;
            end
        end else if (req.wr) begin
            case (req.word)
                W_ENABLE: enable_q <= data_i[N_SRC-1:0];
                W_THRESH: thresh_q <= data_i[PRIO_W-1:0];
                default: begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (req.prio_hit && (req.prio_idx == 6'(i))) begin
                            prio_q[i] <= data_i[PRIO_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // Read mux; unmapped words and unused upper bits return zero.
    always_comb begin
        rd_data = '0;
        case (req.word)
            W_PENDING: rd_data[N_SRC-1:0]  = pending;
            W_ENABLE:  rd_data[N_SRC-1:0]  = enable_q;
            W_THRESH:  rd_data[PRIO_W-1:0] = thresh_q;
            W_CLAIM:   rd_data[7:0]        = winner;
            default: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (req.prio_hit && (req.prio_idx == 6'(i))) begin
                        rd_data[PRIO_W-1:0] = prio_q[i];
                    end
                end
            end
        endcase
    end

    // Registered outputs: flag tracks the winner every cycle; read data holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_flag_o <= 8'd0;
            data_o     <= 32'd0;
        end else begin
            int_flag_o <= winner;
            if (we_i) begin
                data_o <= 32'd0;
            end else if (re_i) begin
                data_o <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed and randomized stimulus against a set-based reference model.
// Model predicts int_flag_o and data_o per edge into a queue; a monitor pops and compares after each edge.
// Directed reads may also carry a fixed expected value which the monitor checks alongside the model.
module tb_int_arbiter;
    localparam int N  = 8;
    localparam int PW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq;
    logic         we;
    logic         re;
    logic [7:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  data_o;
    logic [7:0]   int_flag_o;

    logic         dir_vld;
    logic [31:0]  dir_val;

    int vectors     = 0;
    int miscompares = 0;

    int_arbiter #(.N_SRC(N), .PRIO_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_i      (irq),
        .we_i       (we),
        .re_i       (re),
        .addr_i     (addr),
        .data_i     (wdata),
        .data_o     (data_o),
        .int_flag_o (int_flag_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [N-1:0]  m_pend;
    bit [N-1:0]  m_insv;
    bit [N-1:0]  m_en;
    int          m_thr;
    int          m_prio [N];
    logic [31:0] m_data;
    bit          m_data_known;

    typedef struct {
        logic [7:0]  flag;
        logic [31:0] data;
        bit          data_chk;
        bit          dir_vld;
        logic [31:0] dir_val;
    } exp_t;

    exp_t exp_q [$];

    function automatic bit m_elig(int i);
        return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
    endfunction

    // Find the top priority among eligible sources, then the first source holding it.
    function automatic int m_winner();
        int best = 0;
        for (int i = 0; i < N; i++)
            if (m_elig(i) && m_prio[i] > best) best = m_prio[i];
        if (best == 0) return 0;
        for (int i = 0; i < N; i++)
            if (m_elig(i) && m_prio[i] == best) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(int word);
        if (word == 0) return 32'(m_pend);
        if (word == 1) return 32'(m_en);
        if (word == 2) return 32'(m_thr);
        if (word == 3) return 32'(m_winner());
        if (word >= 4 && word < 4 + N) return 32'(m_prio[word - 4]);
        return 32'd0;
    endfunction

    task automatic model_step();
        exp_t       e;
        bit [N-1:0] idle_pre;
        int         word;
        int         w;
        int         id;
        e.dir_vld = 1'b0;
        e.dir_val = '0;
        if (rst) begin
            m_pend = '0;
            m_insv = '0;
            m_en   = '0;
            m_thr  = 0;
            for (int i = 0; i < N; i++) m_prio[i] = 0;
            m_data       = 32'd0;
            m_data_known = 1'b1;
            e.flag       = 8'd0;
        end else begin
            w         = m_winner();
            e.flag    = 8'(w);
            e.dir_vld = dir_vld;
            e.dir_val = dir_val;
            idle_pre  = ~(m_pend | m_insv);
            word      = int'(addr[7:2]);
            if (we) begin
                m_data       = 32'd0;
                m_data_known = re;
                case (word)
                    1: m_en = wdata[N-1:0];
                    2: m_thr = int'(wdata[PW-1:0]);
                    3: begin
                        id = int'(wdata[7:0]);
                        if (id >= 1 && id <= N && m_insv[id-1]) m_insv[id-1] = 1'b0;
                    end
                    default: if (word >= 4 && word < 4 + N) m_prio[word-4] = int'(wdata[PW-1:0]);
                endcase
            end else if (re) begin
                m_data       = m_read(word);
                m_data_known = 1'b1;
                if (word == 3 && w != 0) begin
                    m_pend[w-1] = 1'b0;
                    m_insv[w-1] = 1'b1;
                end
            end
            m_pend |= idle_pre & irq;
        end
        e.data     = m_data;
        e.data_chk = m_data_known;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("int_flag_o", 32'(int_flag_o), 32'(e.flag));
            if (e.data_chk) chk("data_o", data_o, e.data);
            if (e.dir_vld) chk("directed_read", data_o, e.dir_val);
        end
    end

    // ---------------- stimulus (tasks start and end at a negedge) ----------------
    task automatic wr(logic [7:0] a, logic [31:0] d);
        we = 1'b1; re = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(logic [7:0] a);
        re = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic rd_exp(logic [7:0] a, logic [31:0] v);
        dir_vld = 1'b1; dir_val = v;
        rd(a);
        dir_vld = 1'b0;
    endtask

    task automatic both(logic [7:0] a, logic [31:0] d);
        we = 1'b1; re = 1'b1; addr = a; wdata = d; dir_vld = 1'b1; dir_val = 32'd0;
        @(negedge clk);
        we = 1'b0; re = 1'b0; dir_vld = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int op;
        rst = 1'b1; irq = '0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        dir_vld = 1'b0; dir_val = '0;
        idle(3);
        rst = 1'b0;
        rd_exp(8'h04, 32'h0);

        // Basic request
        wr(8'h18, 32'd3); wr(8'h04, 32'h04); wr(8'h08, 32'd0);
        irq = 8'h04; idle(1); irq = '0;
        rd_exp(8'h00, 32'h04);
        idle(2);
        rd_exp(8'h0C, 32'd3);
        idle(1);
        rd_exp(8'h00, 32'h00);
        wr(8'h0C, 32'd3);
        idle(2);

        // Priority and tie-break
        wr(8'h14, 32'd2); wr(8'h20, 32'd5); wr(8'h28, 32'd5); wr(8'h04, 32'hFF);
        irq = 8'h52; idle(1); irq = '0;
        idle(2);
        rd_exp(8'h0C, 32'd5); rd_exp(8'h0C, 32'd7); rd_exp(8'h0C, 32'd2); rd_exp(8'h0C, 32'd0);
        wr(8'h0C, 32'd5); wr(8'h0C, 32'd7); wr(8'h0C, 32'd2);

        // Threshold and enable gating
        wr(8'h10, 32'd2); wr(8'h08, 32'd2);
        irq = 8'h01; idle(1); irq = '0;
        idle(3);
        rd_exp(8'h0C, 32'd0);
        wr(8'h08, 32'd1); idle(2);
        rd_exp(8'h00, 32'h01);
        wr(8'h04, 32'hFE); idle(2);
        rd_exp(8'h00, 32'h01);
        wr(8'h04, 32'hFF);
        rd_exp(8'h0C, 32'd1);
        wr(8'h0C, 32'd1);

        // Level re-trigger
        irq = 8'h01; idle(3);
        rd_exp(8'h0C, 32'd1);
        idle(10);
        wr(8'h0C, 32'd1);
        idle(3);
        rd_exp(8'h0C, 32'd1);
        irq = '0;
        wr(8'h0C, 32'd1);

        // Bogus completes and collisions
        irq = 8'h12; idle(1); irq = '0; idle(1);
        rd_exp(8'h0C, 32'd5);
        wr(8'h0C, 32'd9); wr(8'h0C, 32'd0); wr(8'h0C, 32'd4); wr(8'h0C, 32'd2);
        rd_exp(8'h00, 32'h02);
        both(8'h0C, 32'd5);
        rd_exp(8'h00, 32'h02);
        rd_exp(8'h0C, 32'd2);
        wr(8'h0C, 32'd2);
        wr(8'h08, 32'hFFFF_FFF9);
        rd_exp(8'h08, 32'd1);
        rd_exp(8'h20, 32'd5);
        rd_exp(8'h80, 32'd0);
        rd_exp(8'hFC, 32'd0);
        wr(8'h00, 32'hFF);
        rd_exp(8'h00, 32'd0);
        rd_exp(8'h13, 32'd2);
        both(8'h04, 32'h0F);
        rd_exp(8'h04, 32'h0F);

        // Reset mid-operation
        wr(8'h04, 32'hFF);
        irq = 8'h53; idle(1); irq = '0; idle(1);
        rd_exp(8'h0C, 32'd5);
        rst = 1'b1; idle(1); rst = 1'b0;
        rd_exp(8'h04, 32'd0); rd_exp(8'h08, 32'd0); rd_exp(8'h20, 32'd0); rd_exp(8'h00, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            op = int'($urandom_range(0, 99));
            if ($urandom_range(0, 3) == 0) irq = 8'($urandom) & 8'($urandom);
            if (n % 700 == 699) begin
                rst = 1'b1; idle(1); rst = 1'b0;
            end else if (op < 35) idle(1);
            else if (op < 55) rd(8'h0C);
            else if (op < 70) wr(8'h0C, 32'($urandom_range(0, 10)));
            else if (op < 76) wr(8'h04, $urandom);
            else if (op < 80) wr(8'h08, $urandom);
            else if (op < 88) wr(8'(32'h10 + 4 * $urandom_range(0, N - 1)), $urandom);
            else if (op < 96) rd(8'($urandom));
            else both(8'(4 * $urandom_range(0, 15)), $urandom);
        end

        irq = '0;
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Platform-level interrupt arbiter for the core. It collects up to N_SRC level-sensitive external interrupt lines, gates them through per-source pending/in-service tracking, and selects the highest-priority eligible source. The winner's ID is driven on `int_flag_o`, which feeds the core-local interrupt controller's `int_flag_i`. A memory-mapped register port provides enable, priority, threshold and the claim/complete handshake.

## Interface
Parameters:
- N_SRC, 8: number of interrupt sources (1..31). Source i has ID i+1; ID 0 means none.
- PRIO_W, 3: priority field width. Priority 0 means never interrupt.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- irq_i  input  N_SRC  level interrupt requests, already synchronous to clk.
- we_i  input  1  register write strobe.
- re_i  input  1  register read strobe.
- addr_i  input  8  byte address; bits [1:0] ignored.
- data_i  input  32  write data.
- data_o  output  32  read data, registered.
- int_flag_o  output  8  winning source ID, zero-extended; 0 = no request. Registered.

## Operation
- Register map:
  - 0x00 PENDING: read-only, bits [N_SRC-1:0]. Writes are ignored.
  - 0x04 ENABLE: RW, bits [N_SRC-1:0].
  - 0x08 THRESHOLD: RW, bits [PRIO_W-1:0].
  - 0x0C CLAIM/COMPLETE: see the handshake below.
  - 0x10+4·i PRIORITY[i]: RW, bits [PRIO_W-1:0].
  - Unmapped reads return 0. Unmapped writes are ignored. Unused upper bits read as 0.
- Per-source gateway FSM:
  - IDLE: irq_i[i]=1 → PEND.
  - PEND: a claim returning ID i+1 → INSV.
  - INSV: a complete write with data_i[7:0]=i+1 → IDLE. While in INSV, irq_i is ignored.
  - PENDING bit i = (state==PEND).
- Eligibility: PEND, ENABLE[i]=1, and PRIORITY[i] > THRESHOLD.
- Arbitration (combinational winner): the eligible source with the highest priority wins. Ties go to the lowest index. If nothing is eligible, the winner is 0.
- int_flag_o <= winner, every cycle.
- Claim: a read of 0x0C returns the current-cycle winner. The winning source moves PEND→INSV at the same edge. A winner of 0 returns 0 and has no side effect.
- Complete: a write to 0x0C with an ID whose source is in INSV returns it to IDLE. Any other ID (0, out of range, not in service) is ignored.
- Multiple sources may be in INSV simultaneously (nesting).
- we_i and re_i asserted together: the write is performed, the read is dropped, and data_o <= 0.
- Changing ENABLE, PRIORITY or THRESHOLD never alters gateway state. It only affects eligibility, from the next winner computation onward.

## Timing
- Reset values: data_o=0, int_flag_o=0, all gateways IDLE, ENABLE=0, THRESHOLD=0, all PRIORITY=0.
- Reset mid-operation discards all pending and in-service state on the next edge.
- irq_i[i] high at edge t → PEND after t → int_flag_o shows ID at edge t+1. Request-to-flag latency is 2 cycles.
- Read with re_i at edge t → data_o valid after t and held until the next read or write strobe. When neither strobe is active, data_o keeps its value.
- Claim at edge t → source in INSV after t → int_flag_o drops to the next winner (or 0) at edge t+1.
- Complete at edge t while irq_i is still high → IDLE after t, PEND after t+1, int_flag_o reasserts after t+2.
- Register writes take effect at the write edge. The resulting int_flag_o change appears one edge later.
- irq_i deasserting while PEND does not clear pending. The gateway holds the request until it is claimed.

## Test plan
- Basic request:
  - Stimulus: PRIORITY[2]=3, ENABLE=0x04, THRESHOLD=0; pulse irq_i[2] for 1 cycle.
  - Response: PENDING=0x04; int_flag_o=3 two cycles after the pulse. Claim read returns 3, then int_flag_o=0 and PENDING=0. Complete with 3 leaves int_flag_o=0.
- Priority and tie-break:
  - Stimulus: sources 1, 4 and 6 pending with priorities 2, 5, 5; all enabled.
  - Response: int_flag_o=5. Successive claims return 5, then 7, then 2, then 0.
- Threshold and enable gating:
  - Stimulus: source 0 pending with PRIORITY=2; THRESHOLD=2.
  - Response: int_flag_o=0. Setting THRESHOLD=1 gives int_flag_o=1. Clearing ENABLE[0] gives int_flag_o=0 while PENDING bit 0 stays 1.
- Level re-trigger:
  - Stimulus: hold irq_i[0] high; claim (returns 1); keep it high for 10 cycles.
  - Response: int_flag_o stays 0 for those 10 cycles. Complete with 1 → int_flag_o=1 two cycles later.
- Bogus complete and collisions:
  - Stimulus: complete with 9, 0, and the ID of an IDLE source.
  - Response: no state change.
  - Stimulus: we_i and re_i together at 0x0C.
  - Response: data_o=0, and the write takes effect.
- Reset mid-operation:
  - Stimulus: assert rst with 3 sources pending and 1 in service.
  - Response: all outputs 0, all registers at reset values.
